// File: rtl/crc_pkg.sv
// Shared types for the CRC frame checker: FSM state encoding and statistics width.
// Imported by crc_frame_checker; crc_parallel is width-parameterised and needs nothing from here.
package crc_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/crc_parallel.sv
// Combinational CRC division step: shifts FRAME_SIZE data bits (MSB first) into the remainder.
// Zero latency, no flow control; the active width is set at run time by the thermometer mask.
module crc_parallel #(
  parameter int CRC_SIZE   = 8,
  parameter int FRAME_SIZE = 8
) (
  input  logic [CRC_SIZE-1:0]   crc_in,
  input  logic [FRAME_SIZE-1:0] data_in,
  input  logic [CRC_SIZE-1:0]   crc_poly,
  input  logic [CRC_SIZE-1:0]   crc_poly_size,
  output logic [CRC_SIZE-1:0]   crc_out
);

  logic [CRC_SIZE-1:0] top_sel;
  logic [CRC_SIZE-1:0] poly_m;
  logic [CRC_SIZE-1:0] rem;
  logic                fb;

  // top_sel isolates the highest active bit of the thermometer mask
  assign top_sel = crc_poly_size & ~(crc_poly_size >> 1);
  assign poly_m  = crc_poly & crc_poly_size;

  always_comb begin
    rem = crc_in & crc_poly_size;
    fb  = 1'b0;
    for (int i = FRAME_SIZE - 1; i >= 0; i--) begin
      fb  = |(rem & top_sel);
      rem = ((rem << 1) | {{(CRC_SIZE-1){1'b0}}, data_in[i]}) & crc_poly_size;
      if (fb) begin
        rem = rem ^ poly_m;
      end
    end
  end

  assign crc_out = rem;

endmodule

// File: rtl/crc_frame_checker.sv
// Streaming CRC code-word checker; result strobe one cycle after the last beat, data_ready low only in RESULT.
// Optional CRC_CHECKER_STATS_EN adds saturating frame/error counters with a stats_clr input.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int CRC_SIZE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CRC_SIZE-1:0]   crc_poly,
  input  logic [CRC_SIZE-1:0]   crc_poly_size,
  input  logic                  crc_poly_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic                  check_valid,
  output logic                  check_ok,
  output logic [CRC_SIZE-1:0]   crc_rem,
`ifdef CRC_CHECKER_STATS_EN
  input  logic                  stats_clr,
  output logic [STATS_W-1:0]    frame_count,
  output logic [STATS_W-1:0]    err_count,
  output logic                  busy
`else
  output logic                  busy
`endif
);

  state_e              state_q, state_d;
  logic [CRC_SIZE-1:0] rem_q, rem_d;
  logic [CRC_SIZE-1:0] poly_q, poly_d;
  logic [CRC_SIZE-1:0] mask_q, mask_d;
  logic [CRC_SIZE-1:0] crc_rem_q, crc_rem_d;
  logic                check_ok_q, check_ok_d;

  logic                accept;
  logic                poly_wr_ok;
  logic [CRC_SIZE-1:0] poly_eff;
  logic [CRC_SIZE-1:0] mask_eff;
  logic [CRC_SIZE-1:0] step_out;

  assign data_ready  = ~rst && (state_q != ST_RESULT);
  assign accept      = data_valid && data_ready;
  assign check_valid = (state_q == ST_RESULT);
  assign busy        = (state_q != ST_IDLE);
  assign crc_rem     = crc_rem_q;
  assign check_ok    = check_ok_q;

  // A write coinciding with the first beat must already steer that beat
  assign poly_wr_ok = crc_poly_wr && (state_q == ST_IDLE);
  assign poly_eff   = poly_wr_ok ? crc_poly      : poly_q;
  assign mask_eff   = poly_wr_ok ? crc_poly_size : mask_q;

  crc_parallel #(
    .CRC_SIZE   (CRC_SIZE),
    .FRAME_SIZE (DATA_WIDTH)
  ) u_step (
    .crc_in        (rem_q),
    .data_in       (data_in),
    .crc_poly      (poly_eff),
    .crc_poly_size (mask_eff),
    .crc_out       (step_out)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    poly_d     = poly_q;
    mask_d     = mask_q;
    crc_rem_d  = crc_rem_q;
    check_ok_d = check_ok_q;

    if (poly_wr_ok) begin
      poly_d = crc_poly;
      mask_d = crc_poly_size;
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          if (data_last) begin
            state_d    = ST_RESULT;
            rem_d      = '0;
            crc_rem_d  = step_out;
            check_ok_d = (step_out == '0);
          end else begin
            state_d = ST_RUN;
            rem_d   = step_out;
          end
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      poly_q     <= '0;
      mask_q     <= '1;
      crc_rem_q  <= '0;
      check_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      poly_q     <= poly_d;
      mask_q     <= mask_d;
      crc_rem_q  <= crc_rem_d;
      check_ok_q <= check_ok_d;
    end
  end

`ifdef CRC_CHECKER_STATS_EN
  logic [STATS_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [STATS_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (stats_clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else if (check_valid) begin
      if (frame_cnt_q != {STATS_W{1'b1}}) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      if (!check_ok_q && (err_cnt_q != {STATS_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker (CRC_SIZE=8, DATA_WIDTH=8): vector table, corner sequences, random frames.
module tb_crc_frame_checker;

  logic       clk;
  logic       rst;
  logic [7:0] crc_poly;
  logic [7:0] crc_poly_size;
  logic       crc_poly_wr;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       check_valid;
  logic       check_ok;
  logic [7:0] crc_rem;
  logic       busy;
`ifdef CRC_CHECKER_STATS_EN
  logic        stats_clr;
  logic [15:0] frame_count;
  logic [15:0] err_count;
`endif

  int checks;
  int failures;
  int cv_count;

  crc_frame_checker #(.CRC_SIZE(8), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .crc_poly      (crc_poly),
    .crc_poly_size (crc_poly_size),
    .crc_poly_wr   (crc_poly_wr),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_last     (data_last),
    .data_ready    (data_ready),
    .check_valid   (check_valid),
    .check_ok      (check_ok),
    .crc_rem       (crc_rem),
`ifdef CRC_CHECKER_STATS_EN
    .stats_clr     (stats_clr),
    .frame_count   (frame_count),
    .err_count     (err_count),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (check_valid) cv_count++;

  typedef struct packed {
    logic [7:0]  poly;
    logic [7:0]  mask;
    logic [3:0]  nb;
    logic [95:0] beats;
    logic [7:0]  exp_rem;
    logic        exp_ok;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] tx_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic write_poly(input logic [7:0] p, input logic [7:0] m);
    crc_poly      = p;
    crc_poly_size = m;
    crc_poly_wr   = 1'b1;
    tick();
    crc_poly_wr   = 1'b0;
  endtask

  // Reference: remainder of the whole code word divided by the generator, via bitwise long division
  function automatic logic [7:0] model_rem(input logic [7:0] poly, input int n);
    int bits [$];
    int g [9];
    int len;
    logic [7:0] r;
    foreach (tx_q[i]) for (int b = 7; b >= 0; b--) bits.push_back(int'(tx_q[i][b]));
    len  = bits.size();
    g[0] = 1;
    for (int k = 1; k <= n; k++) g[k] = int'(poly[n-k]);
    for (int i = 0; i + n < len; i++)
      if (bits[i] == 1)
        for (int k = 0; k <= n; k++) bits[i+k] = bits[i+k] ^ g[k];
    r = 8'h00;
    for (int k = 0; k < n; k++) r = (r << 1) | 8'(bits[len-n+k]);
    return r;
  endfunction

  task automatic drive_frame(input int gap_at, input int gap_len, input bit rnd_gaps);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == gap_at && gap_len > 0) begin
        data_valid = 1'b0;
        repeat (gap_len) tick();
        chk("stall_no_result", check_valid, 1'b0);
        chk("stall_busy", busy, 1'b1);
      end
      if (rnd_gaps) begin
        for (int s = 0; s < 3 && $urandom_range(0, 2) == 0; s++) begin
          data_valid = 1'b0;
          tick();
        end
      end
      data_in    = tx_q[i];
      data_valid = 1'b1;
      data_last  = (i == tx_q.size() - 1);
      chk($sformatf("ready_beat%0d", i), data_ready, 1'b1);
      tick();
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic check_result(input string nm, input logic [7:0] er, input logic eok);
    chk({nm, "_valid"}, check_valid, 1'b1);
    chk({nm, "_rem"}, crc_rem, er);
    chk({nm, "_ok"}, check_ok, eok);
    chk({nm, "_ready_in_result"}, data_ready, 1'b0);
    tick();
    chk({nm, "_strobe_one_cycle"}, check_valid, 1'b0);
  endtask

  task automatic load_std_frame(input logic [7:0] last_beat);
    tx_q.delete();
    for (int i = 0; i < 9; i++) tx_q.push_back(8'h31 + 8'(i));
    tx_q.push_back(last_beat);
  endtask

  initial begin
    checks = 0; failures = 0; cv_count = 0;
    rst = 1'b1; crc_poly = 8'h00; crc_poly_size = 8'h00; crc_poly_wr = 1'b0;
    data_in = 8'h00; data_valid = 1'b0; data_last = 1'b0;
`ifdef CRC_CHECKER_STATS_EN
    stats_clr = 1'b0;
`endif

    vecs[0] = '{8'h07, 8'hFF, 4'd10, 96'h31323334_35363738_39F40000, 8'h00, 1'b1};
    vecs[1] = '{8'h07, 8'hFF, 4'd1,  96'h00000000_00000000_00000000, 8'h00, 1'b1};
    vecs[2] = '{8'h07, 8'hFF, 4'd1,  96'h05000000_00000000_00000000, 8'h05, 1'b0};
    vecs[3] = '{8'h03, 8'h0F, 4'd1,  96'hA5000000_00000000_00000000, 8'h08, 1'b0};
    vecs[4] = '{8'h07, 8'hFF, 4'd2,  96'h12340000_00000000_00000000, 8'h4A, 1'b0};
    vecs[5] = '{8'h07, 8'hFF, 4'd10, 96'h31323334_35363738_39F50000, 8'h01, 1'b0};

    // Reset state
    repeat (2) tick();
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_valid", check_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rem", crc_rem, 8'h00);
    chk("rst_ok", check_ok, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_ready", data_ready, 1'b1);

    // Reset mask is all-ones with poly 0: an 8-bit word comes back unchanged
    tx_q.delete(); tx_q.push_back(8'hA5);
    drive_frame(-1, 0, 1'b0);
    check_result("reset_mask", 8'hA5, 1'b0);

`ifdef CRC_CHECKER_STATS_EN
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("stats_cleared", frame_count, 16'd0);
`endif

    foreach (vecs[v]) begin
      write_poly(vecs[v].poly, vecs[v].mask);
      tx_q.delete();
      for (int i = 0; i < int'(vecs[v].nb); i++) tx_q.push_back(vecs[v].beats[95-8*i -: 8]);
      drive_frame(-1, 0, 1'b0);
      check_result($sformatf("vec%0d", v), vecs[v].exp_rem, vecs[v].exp_ok);
    end
    repeat (3) tick();
    chk("hold_rem", crc_rem, 8'h01);
    chk("hold_ok", check_ok, 1'b0);
`ifdef CRC_CHECKER_STATS_EN
    chk("stats_frames", frame_count, 16'd6);
    chk("stats_errs", err_count, 16'd4);
`endif

    // Five idle cycles mid-frame
    load_std_frame(8'hF4);
    drive_frame(4, 5, 1'b0);
    check_result("stall", 8'h00, 1'b1);

    // Poly write during RUN must be ignored
    load_std_frame(8'hF4);
    for (int i = 0; i < 4; i++) begin
      data_in = tx_q[i]; data_valid = 1'b1; data_last = 1'b0; tick();
    end
    data_valid = 1'b0; crc_poly = 8'h1D; crc_poly_size = 8'hFF; crc_poly_wr = 1'b1;
    tick();
    crc_poly_wr = 1'b0;
    for (int i = 4; i < 10; i++) begin
      data_in = tx_q[i]; data_valid = 1'b1; data_last = (i == 9); tick();
    end
    data_valid = 1'b0; data_last = 1'b0;
    check_result("wr_in_run", 8'h00, 1'b1);
    load_std_frame(8'hF4);
    drive_frame(-1, 0, 1'b0);
    check_result("wr_in_run_after", 8'h00, 1'b1);

    // Poly write coinciding with the first beat applies to that beat
    write_poly(8'h03, 8'h0F);
    load_std_frame(8'hF4);
    crc_poly = 8'h07; crc_poly_size = 8'hFF; crc_poly_wr = 1'b1;
    data_in = tx_q[0]; data_valid = 1'b1; data_last = 1'b0; tick();
    crc_poly_wr = 1'b0;
    for (int i = 1; i < 10; i++) begin
      data_in = tx_q[i]; data_valid = 1'b1; data_last = (i == 9); tick();
    end
    data_valid = 1'b0; data_last = 1'b0;
    check_result("wr_with_first_beat", 8'h00, 1'b1);

    // Reset mid-frame discards it; only the following frame reports
    load_std_frame(8'hF4);
    cv_count = 0;
    for (int i = 0; i < 4; i++) begin
      data_in = tx_q[i]; data_valid = 1'b1; data_last = 1'b0; tick();
    end
    data_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", data_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    write_poly(8'h07, 8'hFF);
    drive_frame(-1, 0, 1'b0);
    check_result("after_midrst", 8'h00, 1'b1);
    tick();
    chk("midrst_pulse_count", cv_count, 1);

    // Random frames against the long-division model
    for (int t = 0; t < 40; t++) begin
      int n;
      int nb;
      logic [7:0] p, m, er;
      n  = $urandom_range(1, 8);
      m  = 8'((9'd1 << n) - 9'd1);
      p  = 8'($urandom) & m;
      nb = $urandom_range(1, 8);
      tx_q.delete();
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
      if (n == 8 && $urandom_range(0, 1) == 1) begin
        tx_q.push_back(8'h00);
        tx_q[tx_q.size()-1] = model_rem(p, 8);
      end
      er = model_rem(p, n);
      write_poly(p, m);
      drive_frame(-1, 0, 1'b1);
      check_result($sformatf("rnd%0d", t), er, er == 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
